// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver: FSM state encoding and
// the bit-period divider calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through read port. A push into a full
// FIFO succeeds only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNTW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: mid-bit sampling receiver feeding a FWFT FIFO, and a
// valid/ready transmitter, with sticky overflow and framing error flags.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 27_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 4
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    output logic                        uart_tx,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overflow,
    output logic                        rx_frame_err,
    input  logic                        err_clr
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int RCW = $clog2(DIV);
    localparam int TCW = $clog2(STOP_BITS * DIV);

    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_d;
    uart_state_e          rx_state;
    logic [RCW-1:0]       rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 stop_sample;
    logic                 rx_push;
    logic                 frame_bad;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_state_e          tx_state;
    logic [TCW-1:0]       tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign stop_sample = (rx_state == STOP) && (rx_cnt == '0);
    assign rx_push     = stop_sample && rxs;
    assign frame_bad   = stop_sample && !rxs;

    // Receiver: a half-period delay after the falling edge puts every later sample mid-bit.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        rx_cnt   <= RCW'(DIV / 2 - 1);
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == '0) begin
                        if (!rxs) begin
                            rx_cnt   <= RCW'(DIV - 1);
                            rx_bit   <= '0;
                            rx_state <= DATA;
                        end else begin
                            rx_state <= IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - RCW'(1);
                    end
                end
                DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        rx_cnt   <= RCW'(DIV - 1);
                        if (rx_bit == 3'(DATA_BITS - 1)) begin
                            rx_state <= STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - RCW'(1);
                    end
                end
                STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - RCW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_shift),
        .full      (fifo_full),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_valid = !fifo_empty;

    // Sticky error flags: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_push && fifo_full && !rx_ready) begin
                rx_overflow <= 1'b1;
            end else if (err_clr) begin
                rx_overflow <= 1'b0;
            end
            if (frame_bad) begin
                rx_frame_err <= 1'b1;
            end else if (err_clr) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        uart_tx  <= 1'b0;
                        tx_cnt   <= TCW'(DIV - 1);
                        tx_ready <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == '0) begin
                        uart_tx  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                        tx_bit   <= '0;
                        tx_cnt   <= TCW'(DIV - 1);
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt - TCW'(1);
                    end
                end
                DATA: begin
                    if (tx_cnt == '0) begin
                        if (tx_bit == 3'(DATA_BITS - 1)) begin
                            uart_tx  <= 1'b1;
                            tx_cnt   <= TCW'(STOP_BITS * DIV - 1);
                            tx_state <= STOP;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                            tx_bit   <= tx_bit + 3'd1;
                            tx_cnt   <= TCW'(DIV - 1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt - TCW'(1);
                    end
                end
                STOP: begin
                    if (tx_cnt == '0) begin
                        tx_ready <= 1'b1;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - TCW'(1);
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core at DIV=16: RX bytes and TX line levels are
// queued as expectations when stimulus is driven and checked as the DUT produces them.
module tb_uart_core;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int BIT    = 16;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_count;
    logic       rx_overflow;
    logic       rx_frame_err;
    logic       err_clr;

    logic       tx_valid2;
    logic       uart_tx2;
    logic       tx_ready2;
    logic [7:0] rx_data2;
    logic       rx_valid2;
    logic [2:0] rx_count2;
    logic       rx_overflow2;
    logic       rx_frame_err2;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] rxq[$];
    logic       txq[$];

    always #5 sys_clk = ~sys_clk;

    uart_core #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1), .RX_DEPTH(4)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err),
        .err_clr(err_clr)
    );

    uart_core #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(2), .RX_DEPTH(4)
    ) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx(1'b1), .uart_tx(uart_tx2),
        .tx_data(tx_data), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(1'b0),
        .rx_count(rx_count2), .rx_overflow(rx_overflow2), .rx_frame_err(rx_frame_err2),
        .err_clr(1'b0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame on uart_rx starting at a negedge; optionally pops the FIFO head exactly
    // in the cycle whose closing edge pushes this frame's byte (stop mid-sample is 155 cycles in).
    task automatic applyStimulus(input logic [7:0] b, input logic stop_level, input bit pop_mid);
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge sys_clk);
        end
        uart_rx = stop_level;
        if (pop_mid) begin
            repeat (10) @(negedge sys_clk);
            if (rxq.size() == 0) begin
                checkOutput("mid_pop_queue", 32'd0, 32'd1);
            end else begin
                checkOutput("mid_pop_data", {24'd0, rx_data}, {24'd0, rxq.pop_front()});
            end
            rx_ready = 1'b1;
            @(negedge sys_clk);
            rx_ready = 1'b0;
            repeat (5) @(negedge sys_clk);
        end else begin
            repeat (BIT) @(negedge sys_clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic popCheck(input string tag);
        int n = 0;
        while (!rx_valid && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (!rx_valid) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (rxq.size() == 0) begin
            checkOutput({tag, "_unexpected"}, {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
            checkOutput(tag, {24'd0, rx_data}, {24'd0, rxq.pop_front()});
        end
        rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_ready = 1'b0;
    endtask

    // Sends one byte on either instance and checks each line level mid-bit plus tx_ready low time.
    task automatic txFrame(input logic [7:0] b, input bit sel);
        int  low_cycles = -1;
        logic rdy;
        logic line;
        int  exp_low = sel ? 11 * BIT : 10 * BIT;
        txq.push_back(1'b0);
        for (int i = 0; i < 8; i++) txq.push_back(b[i]);
        txq.push_back(1'b1);
        @(negedge sys_clk);
        tx_data = b;
        if (sel) tx_valid2 = 1'b1; else tx_valid = 1'b1;
        @(negedge sys_clk);
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            rdy  = sel ? tx_ready2 : tx_ready;
            line = sel ? uart_tx2 : uart_tx;
            if (n == 40) tx_data = 8'hFF;
            if ((n % BIT) == 8 && (n / BIT) < 10 && txq.size() > 0) begin
                checkOutput($sformatf("tx%0d_bit%0d", sel, n / BIT), {31'd0, line}, {31'd0, txq.pop_front()});
            end
            if (rdy) begin
                low_cycles = n - 1;
                break;
            end
            @(negedge sys_clk);
        end
        checkOutput($sformatf("tx%0d_ready_low", sel), low_cycles, exp_low);
        txq.delete();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        rx_ready  = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("rst_rx_count", {29'd0, rx_count}, 32'd0);
        checkOutput("rst_overflow", {31'd0, rx_overflow}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        $display("[TB] single byte receive");
        applyStimulus(8'h55, 1'b1, 1'b0);
        rxq.push_back(8'h55);
        checkOutput("rx1_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("rx1_count", {29'd0, rx_count}, 32'd1);
        popCheck("rx1_data");
        checkOutput("rx1_valid_after_pop", {31'd0, rx_valid}, 32'd0);

        $display("[TB] transmit");
        txFrame(8'hA3, 1'b0);
        txFrame(8'h5C, 1'b0);
        txFrame(8'hA3, 1'b1);

        $display("[TB] overflow");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0);
            if (i <= 4) rxq.push_back(8'(i));
        end
        checkOutput("ovf_count", {29'd0, rx_count}, 32'd4);
        checkOutput("ovf_flag", {31'd0, rx_overflow}, 32'd1);
        for (int i = 1; i <= 4; i++) popCheck($sformatf("ovf_pop%0d", i));
        checkOutput("ovf_empty", {31'd0, rx_valid}, 32'd0);
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        checkOutput("ovf_cleared", {31'd0, rx_overflow}, 32'd0);

        $display("[TB] framing error");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("frm_flag", {31'd0, rx_frame_err}, 32'd1);
        checkOutput("frm_count", {29'd0, rx_count}, 32'd0);
        repeat (20) @(negedge sys_clk);
        applyStimulus(8'h7E, 1'b1, 1'b0);
        rxq.push_back(8'h7E);
        popCheck("frm_next_data");
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        checkOutput("frm_cleared", {31'd0, rx_frame_err}, 32'd0);

        $display("[TB] glitch rejection");
        uart_rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge sys_clk);
        checkOutput("glitch_count", {29'd0, rx_count}, 32'd0);
        checkOutput("glitch_frame_err", {31'd0, rx_frame_err}, 32'd0);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        rxq.push_back(8'hA5);
        popCheck("glitch_next_data");

        $display("[TB] push and pop while full");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0);
            rxq.push_back(8'h10 + 8'(i));
        end
        checkOutput("full_count", {29'd0, rx_count}, 32'd4);
        applyStimulus(8'h14, 1'b1, 1'b1);
        rxq.push_back(8'h14);
        checkOutput("full_pp_count", {29'd0, rx_count}, 32'd4);
        checkOutput("full_pp_overflow", {31'd0, rx_overflow}, 32'd0);
        for (int i = 0; i < 4; i++) popCheck($sformatf("full_pp_pop%0d", i));
        checkOutput("full_pp_empty", {31'd0, rx_valid}, 32'd0);

        $display("[TB] reset during transmit");
        @(negedge sys_clk);
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        repeat (49) @(negedge sys_clk);
        checkOutput("midtx_line_low", {31'd0, uart_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midtx_rst_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("midtx_rst_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        txFrame(8'hA3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
